// File: rtl/calc_phase_sequencer_if.sv
// Signal bundle between calc_phase_sequencer and its environment: top-level
// handshake, PreProcess, Calculator_FSM and the shared Data_Ram port.
// The master side is the sequencer; the slave side is everything around it.
interface calc_phase_sequencer_if #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int INSTR_AW = 6
);
  // top-level handshake and status
  logic                Start;
  logic                Busy;
  logic                Finish;
  logic                Fault;
  logic [1:0]          Fault_Code;
  logic [DATA_W-1:0]   Result;
  // preprocessor side
  logic [INSTR_AW-1:0] Instr_Addr;
  logic                Pre_En;
  logic [ADDR_W-1:0]   Pre_Rd_Ptr;
  logic [ADDR_W-1:0]   Pre_Wr_Ptr;
  logic [DATA_W-1:0]   Pre_Dout;
  logic                Pre_Finish;
  // calculator FSM side
  logic                Fsm_En;
  logic [ADDR_W-1:0]   Fsm_Ptr;
  logic [DATA_W-1:0]   Fsm_Instr;
  logic                Fsm_Finish;
  logic                Fsm_Fault;
  logic [DATA_W-1:0]   Fsm_Result;
  // shared RAM port
  logic                Ram_Wr;
  logic [ADDR_W-1:0]   Ram_Addr;
  logic [DATA_W-1:0]   Ram_Din;
  logic [DATA_W-1:0]   Ram_Dout;

  modport master (
    input  Start, Pre_Rd_Ptr, Pre_Wr_Ptr, Pre_Dout, Pre_Finish,
           Fsm_Ptr, Fsm_Finish, Fsm_Fault, Fsm_Result, Ram_Dout,
    output Busy, Finish, Fault, Fault_Code, Result, Instr_Addr, Pre_En,
           Fsm_En, Fsm_Instr, Ram_Wr, Ram_Addr, Ram_Din
  );

  modport slave (
    output Start, Pre_Rd_Ptr, Pre_Wr_Ptr, Pre_Dout, Pre_Finish,
           Fsm_Ptr, Fsm_Finish, Fsm_Fault, Fsm_Result, Ram_Dout,
    input  Busy, Finish, Fault, Fault_Code, Result, Instr_Addr, Pre_En,
           Fsm_En, Fsm_Instr, Ram_Wr, Ram_Addr, Ram_Din
  );
endinterface

// File: rtl/calc_phase_sequencer.sv
// Sequences one calculation: PreProcess fills Data_Ram (PRE), one turnaround
// cycle (GAP), then Calculator_FSM reads it back (EVAL). Owns the RAM port
// mux, the start/finish handshake, a per-phase watchdog and fault reporting.
module calc_phase_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int INSTR_AW = 6,
  parameter int TIMEOUT  = 1023
) (
  input logic                 Sysclk,
  input logic                 Rst_n,
  calc_phase_sequencer_if.master bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_EVAL = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_FSM     = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;
  localparam logic [1:0] FC_OVFL    = 2'b11;

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [CNT_W-1:0]  phase_cnt;
  logic              timed_out;
  logic [1:0]        err_code;      // code to load when entering ERR
  logic              load_result;
  logic              restart;       // IDLE entered from DONE/ERR: go on to PRE
  logic              finish_q;
  logic              fault_q;
  logic [1:0]        code_q;
  logic [DATA_W-1:0] result_q;

  assign timed_out = (phase_cnt == CNT_LIMIT);

  // Next-state selection; within a phase, finish/fault beat overflow beat timeout.
  always_comb begin
    next_state  = state;
    err_code    = FC_NONE;
    load_result = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.Start || restart) next_state = S_PRE;
        else                      next_state = S_IDLE;
      end
      S_PRE: begin
        if (bus.Pre_Finish) begin
          next_state = S_GAP;
        end else if (bus.Pre_Wr_Ptr == ADDR_LAST) begin
          next_state = S_ERR;
          err_code   = FC_OVFL;
        end else if (timed_out) begin
          next_state = S_ERR;
          err_code   = FC_TIMEOUT;
        end else begin
          next_state = S_PRE;
        end
      end
      S_GAP: begin
        next_state = S_EVAL;
      end
      S_EVAL: begin
        if (bus.Fsm_Fault) begin
          next_state = S_ERR;
          err_code   = FC_FSM;
        end else if (bus.Fsm_Finish) begin
          next_state  = S_DONE;
          load_result = 1'b1;
        end else if (timed_out) begin
          next_state = S_ERR;
          err_code   = FC_TIMEOUT;
        end else begin
          next_state = S_EVAL;
        end
      end
      S_DONE, S_ERR: begin
        if (bus.Start) next_state = S_IDLE;
        else           next_state = state;
      end
      default: begin
        // unused encodings are treated as a controller fault
        next_state = S_ERR;
        err_code   = FC_FSM;
      end
    endcase
  end

  // State register; reset aborts any phase at once.
  always_ff @(posedge Sysclk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Remember that IDLE was entered by a restart so PRE follows without a new Start.
  always_ff @(posedge Sysclk or negedge Rst_n) begin
    if (!Rst_n)                                             restart <= 1'b0;
    else if ((state == S_DONE || state == S_ERR) && bus.Start) restart <= 1'b1;
    else if (state == S_IDLE)                               restart <= 1'b0;
    else                                                    restart <= restart;
  end

  // Phase watchdog: counts while staying in PRE or EVAL, zero everywhere else.
  always_ff @(posedge Sysclk or negedge Rst_n) begin
    if (!Rst_n)
      phase_cnt <= '0;
    else if ((state == S_PRE || state == S_EVAL) && next_state == state)
      phase_cnt <= phase_cnt + CNT_W'(1);
    else
      phase_cnt <= '0;
  end

  // Registered status: set on entry to DONE/ERR, cleared by an accepted restart.
  always_ff @(posedge Sysclk or negedge Rst_n) begin
    if (!Rst_n) begin
      finish_q <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= FC_NONE;
    end else if (next_state == S_ERR && state != S_ERR) begin
      finish_q <= 1'b0;
      fault_q  <= 1'b1;
      code_q   <= err_code;
    end else if (next_state == S_DONE && state != S_DONE) begin
      finish_q <= 1'b1;
      fault_q  <= 1'b0;
      code_q   <= FC_NONE;
    end else if ((state == S_DONE || state == S_ERR) && bus.Start) begin
      finish_q <= 1'b0;
      fault_q  <= 1'b0;
      code_q   <= FC_NONE;
    end else begin
      finish_q <= finish_q;
      fault_q  <= fault_q;
      code_q   <= code_q;
    end
  end

  // Result capture on the same edge the FSM finish is accepted.
  always_ff @(posedge Sysclk or negedge Rst_n) begin
    if (!Rst_n)           result_q <= '0;
    else if (load_result) result_q <= bus.Fsm_Result;
    else                  result_q <= result_q;
  end

  // Enables and RAM port mux decoded from the state; writes only ever in PRE.
  always_comb begin
    bus.Busy       = 1'b0;
    bus.Pre_En     = 1'b0;
    bus.Fsm_En     = 1'b0;
    bus.Ram_Wr     = 1'b0;
    bus.Ram_Addr   = '0;
    bus.Ram_Din    = '0;
    bus.Instr_Addr = '0;
    bus.Fsm_Instr  = '0;
    case (state)
      S_PRE: begin
        bus.Busy       = 1'b1;
        bus.Pre_En     = 1'b1;
        bus.Ram_Wr     = ~bus.Pre_Finish;
        bus.Ram_Addr   = bus.Pre_Wr_Ptr;
        bus.Ram_Din    = bus.Pre_Dout;
        bus.Instr_Addr = bus.Pre_Rd_Ptr[INSTR_AW-1:0];
      end
      S_GAP: begin
        // bus turnaround: preprocessor holds its finish, nobody drives RAM
        bus.Busy   = 1'b1;
        bus.Pre_En = 1'b1;
      end
      S_EVAL: begin
        bus.Busy      = 1'b1;
        bus.Pre_En    = 1'b1;
        bus.Fsm_En    = 1'b1;
        bus.Ram_Addr  = bus.Fsm_Ptr;
        bus.Fsm_Instr = bus.Ram_Dout;
      end
      default: begin
        bus.Busy = 1'b0;
      end
    endcase
  end

  assign bus.Finish     = finish_q;
  assign bus.Fault      = fault_q;
  assign bus.Fault_Code = code_q;
  assign bus.Result     = result_q;

endmodule

// File: tb/tb_calc_phase_sequencer.sv
// Directed bench for calc_phase_sequencer: one instance with a small address
// space and short watchdog so overflow and timeout are reachable quickly.
module tb_calc_phase_sequencer;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 16;
  localparam int INSTR_AW = 4;
  localparam int TIMEOUT  = 20;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  calc_phase_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INSTR_AW(INSTR_AW)) bus ();

  calc_phase_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INSTR_AW(INSTR_AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .Sysclk (clk),
    .Rst_n  (rst_n),
    .bus    (bus)
  );

  // free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Start = 1'b0; bus.Pre_Rd_Ptr = '0; bus.Pre_Wr_Ptr = '0; bus.Pre_Dout = '0;
    bus.Pre_Finish = 1'b0; bus.Fsm_Ptr = '0; bus.Fsm_Finish = 1'b0;
    bus.Fsm_Fault = 1'b0; bus.Fsm_Result = '0; bus.Ram_Dout = '0;
  endtask

  // restart from DONE/ERR: one IDLE cycle with enables low, then PRE
  task automatic restart(input string tag);
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    #1;
    check({tag, "_idle_finish"}, {31'd0, bus.Finish}, 32'd0);
    check({tag, "_idle_fault"},  {31'd0, bus.Fault},  32'd0);
    check({tag, "_idle_code"},   {30'd0, bus.Fault_Code}, 32'd0);
    check({tag, "_idle_en"},     {30'd0, bus.Pre_En, bus.Fsm_En}, 32'd0);
    tick();
    check({tag, "_pre_en"}, {30'd0, bus.Pre_En, bus.Fsm_En}, 32'd2);
  endtask

  // watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    rst_n = 1'b0;
    #23;
    // reset state
    check("rst_busy",   {31'd0, bus.Busy}, 32'd0);
    check("rst_en",     {30'd0, bus.Pre_En, bus.Fsm_En}, 32'd0);
    check("rst_status", {30'd0, bus.Finish, bus.Fault}, 32'd0);
    check("rst_code",   {30'd0, bus.Fault_Code}, 32'd0);
    check("rst_result", {16'd0, bus.Result}, 32'd0);
    check("rst_ramwr",  {31'd0, bus.Ram_Wr}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_hold", {31'd0, bus.Busy}, 32'd0);

    // FSM fault with simultaneous finish: fault wins, Result untouched
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    bus.Pre_Finish = 1'b1;
    #1;
    check("f_pre_busy", {31'd0, bus.Busy}, 32'd1);
    check("f_pre_wr_forced0", {31'd0, bus.Ram_Wr}, 32'd0);
    tick();  // GAP
    tick();  // EVAL
    check("f_eval_en", {30'd0, bus.Pre_En, bus.Fsm_En}, 32'd3);
    bus.Fsm_Fault = 1'b1; bus.Fsm_Finish = 1'b1; bus.Fsm_Result = 16'h0077;
    tick();
    bus.Fsm_Fault = 1'b0; bus.Fsm_Finish = 1'b0; bus.Pre_Finish = 1'b0;
    #1;
    check("f_fault",  {31'd0, bus.Fault}, 32'd1);
    check("f_finish", {31'd0, bus.Finish}, 32'd0);
    check("f_code",   {30'd0, bus.Fault_Code}, 32'd1);
    check("f_result", {16'd0, bus.Result}, 32'd0);
    check("f_en",     {30'd0, bus.Pre_En, bus.Fsm_En}, 32'd0);
    check("f_busy",   {31'd0, bus.Busy}, 32'd0);

    // nominal run: 5 writes, GAP, 5 reads, finish with 0x2A
    restart("n");
    for (int i = 0; i < 5; i++) begin
      bus.Pre_Wr_Ptr = 4'(i); bus.Pre_Rd_Ptr = 4'(i + 3); bus.Pre_Dout = 16'h0100 + 16'(i);
      #1;
      check("n_wr",    {31'd0, bus.Ram_Wr}, 32'd1);
      check("n_addr",  {28'd0, bus.Ram_Addr}, i);
      check("n_din",   {16'd0, bus.Ram_Din}, 32'h0100 + i);
      check("n_iaddr", {28'd0, bus.Instr_Addr}, i + 3);
      tick();
    end
    bus.Pre_Wr_Ptr = 4'd5; bus.Pre_Finish = 1'b1;
    #1;
    check("n_fin_wr0", {31'd0, bus.Ram_Wr}, 32'd0);
    tick();  // GAP
    check("n_gap_wr",   {31'd0, bus.Ram_Wr}, 32'd0);
    check("n_gap_en",   {30'd0, bus.Pre_En, bus.Fsm_En}, 32'd2);
    check("n_gap_addr", {28'd0, bus.Ram_Addr}, 32'd0);
    check("n_gap_busy", {31'd0, bus.Busy}, 32'd1);
    tick();  // EVAL
    for (int j = 0; j < 5; j++) begin
      bus.Fsm_Ptr = 4'(j); bus.Ram_Dout = 16'h0200 + 16'(j);
      bus.Start = (j == 2) ? 1'b1 : 1'b0;
      #1;
      check("n_eval_addr",  {28'd0, bus.Ram_Addr}, j);
      check("n_eval_instr", {16'd0, bus.Fsm_Instr}, 32'h0200 + j);
      check("n_eval_wr",    {31'd0, bus.Ram_Wr}, 32'd0);
      tick();
    end
    bus.Start = 1'b0;
    check("n_start_ignored", {30'd0, bus.Pre_En, bus.Fsm_En}, 32'd3);
    bus.Fsm_Finish = 1'b1; bus.Fsm_Result = 16'h002A;
    tick();
    bus.Fsm_Finish = 1'b0; bus.Pre_Finish = 1'b0;
    #1;
    check("n_finish", {31'd0, bus.Finish}, 32'd1);
    check("n_result", {16'd0, bus.Result}, 32'h002A);
    check("n_code",   {30'd0, bus.Fault_Code}, 32'd0);
    check("n_done_en", {30'd0, bus.Pre_En, bus.Fsm_En}, 32'd0);
    check("n_done_wr", {31'd0, bus.Ram_Wr}, 32'd0);
    check("n_done_instr", {16'd0, bus.Fsm_Instr}, 32'd0);

    // restart from DONE and a short second run
    restart("r");
    bus.Pre_Finish = 1'b1;
    tick();  // GAP
    tick();  // EVAL
    bus.Pre_Finish = 1'b0;
    bus.Fsm_Finish = 1'b1; bus.Fsm_Result = 16'h0055;
    tick();
    bus.Fsm_Finish = 1'b0;
    #1;
    check("r_finish", {31'd0, bus.Finish}, 32'd1);
    check("r_result", {16'd0, bus.Result}, 32'h0055);

    // timeout in PRE: still PRE after 20 cycles, ERR on the 21st
    restart("t");
    bus.Pre_Wr_Ptr = 4'd3;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      check("t_still_pre", {31'd0, bus.Busy}, 32'd1);
    end
    tick();
    check("t_fault",  {31'd0, bus.Fault}, 32'd1);
    check("t_code",   {30'd0, bus.Fault_Code}, 32'd2);
    check("t_pre_en", {31'd0, bus.Pre_En}, 32'd0);
    check("t_result", {16'd0, bus.Result}, 32'h0055);

    // RAM overflow: write pointer at 15 without finish
    restart("o");
    bus.Pre_Wr_Ptr = 4'd14;
    #1;
    check("o_wr14", {31'd0, bus.Ram_Wr}, 32'd1);
    tick();
    bus.Pre_Wr_Ptr = 4'd15;
    #1;
    check("o_wr15", {31'd0, bus.Ram_Wr}, 32'd1);
    tick();
    check("o_fault", {31'd0, bus.Fault}, 32'd1);
    check("o_code",  {30'd0, bus.Fault_Code}, 32'd3);
    check("o_wr",    {31'd0, bus.Ram_Wr}, 32'd0);
    check("o_addr",  {28'd0, bus.Ram_Addr}, 32'd0);
    bus.Pre_Wr_Ptr = 4'd0;

    // async reset in the middle of EVAL
    restart("a");
    bus.Pre_Finish = 1'b1;
    tick();  // GAP
    tick();  // EVAL
    bus.Pre_Finish = 1'b0;
    check("a_eval_en", {30'd0, bus.Pre_En, bus.Fsm_En}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("a_en",     {30'd0, bus.Pre_En, bus.Fsm_En}, 32'd0);
    check("a_busy",   {31'd0, bus.Busy}, 32'd0);
    check("a_result", {16'd0, bus.Result}, 32'd0);
    check("a_status", {30'd0, bus.Finish, bus.Fault}, 32'd0);
    #3;
    rst_n = 1'b1;
    for (int m = 0; m < 3; m++) begin
      tick();
      check("a_stay_idle", {31'd0, bus.Busy}, 32'd0);
    end
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    check("a_start_pre", {31'd0, bus.Busy}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_phase_sequencer.md
Name: calc_phase_sequencer

Overview:
Registered controller that sequences one calculation: a preprocess phase, then an evaluate phase. It shares the single Data_Ram port between the preprocessor (writer) and the calculator FSM (reader). It replaces ad-hoc enable/mux logic with an explicit state machine, start/finish handshake, phase watchdog and fault reporting. It sits between the top level, PreProcess, Calculator_FSM and Data_Ram.

Parameters:
ADDR_W, 8, Data_Ram address width
DATA_W, 16, Data_Ram / result word width
INSTR_AW, 6, instruction ROM address width
TIMEOUT, 1023, max cycles allowed per phase before timeout fault

Ports:
Sysclk  in  1  system clock, all state on rising edge
Rst_n  in  1  asynchronous active-low reset
Start  in  1  start request; sampled only in IDLE, DONE or ERR
Busy  out  1  high in PRE, GAP, EVAL
Finish  out  1  high in DONE, held until next accepted Start
Fault  out  1  high in ERR, held until next accepted Start
Fault_Code  out  2  01 FSM fault, 10 timeout, 11 RAM overflow, 00 none
Result  out  DATA_W  result latched on FSM finish
Instr_Addr  out  INSTR_AW  = Pre_Rd_Ptr[INSTR_AW-1:0] in PRE, else 0
Pre_En  out  1  preprocessor enable
Pre_Rd_Ptr  in  ADDR_W  preprocessor read pointer
Pre_Wr_Ptr  in  ADDR_W  preprocessor write pointer
Pre_Dout  in  DATA_W  preprocessor output word
Pre_Finish  in  1  preprocessor done (level)
Fsm_En  out  1  calculator FSM enable
Fsm_Ptr  in  ADDR_W  FSM scan pointer
Fsm_Instr  out  DATA_W  = Ram_Dout in EVAL, else 0
Fsm_Finish  in  1  FSM done (level)
Fsm_Fault  in  1  FSM fault (level)
Fsm_Result  in  DATA_W  FSM result
Ram_Wr  out  1  RAM write enable
Ram_Addr  out  ADDR_W  RAM address
Ram_Din  out  DATA_W  RAM write data
Ram_Dout  in  DATA_W  RAM read data

Behaviour:
- Reset (Rst_n=0, async): state IDLE. All outputs 0, phase counter 0. Reset mid-phase aborts immediately. Pre_En and Fsm_En drop asynchronously, so the sub-blocks reinitialise.
- States: IDLE, PRE, GAP, EVAL, DONE, ERR. The state register is binary encoded. Outputs decode combinationally from the state, except Result, Fault_Code and Finish/Fault, which are registered.
- IDLE: enables 0. Start=1 -> PRE next cycle and clear the phase counter.
- PRE:
  - Pre_En=1, Ram_Wr=1, Ram_Addr=Pre_Wr_Ptr, Ram_Din=Pre_Dout.
  - Pre_Finish=1 -> GAP. Ram_Wr is forced 0 in the cycle Pre_Finish is seen.
  - Pre_Wr_Ptr = 2^ADDR_W-1 and Pre_Finish=0 -> ERR, code 11.
- GAP: exactly one cycle. Pre_En stays 1 (holds its finish), Ram_Wr=0, Fsm_En=0. This is the bus turnaround. -> EVAL.
- EVAL:
  - Pre_En=1, Fsm_En=1, Ram_Wr=0, Ram_Addr=Fsm_Ptr, Fsm_Instr=Ram_Dout.
  - Fsm_Fault=1 -> ERR, code 01. Fault has priority over a simultaneous Fsm_Finish.
  - Fsm_Finish=1 (no fault) -> DONE, and Result <= Fsm_Result on the same edge.
- Watchdog: the phase counter increments every cycle in PRE and in EVAL. It clears on entering PRE and on entering EVAL. When the counter reaches TIMEOUT in either phase -> ERR, code 10. Timeout is lower priority than finish or fault in the same cycle.
- DONE: Finish=1, enables 0, Result held.
- ERR: Fault=1, enables 0, Result held at its previous value.
- Start=1 in DONE or ERR: clear Finish/Fault/Fault_Code -> IDLE for one cycle, with enables low so the sub-blocks reinitialise -> PRE.
- Start in PRE, GAP or EVAL is ignored. No queueing.
- Ram_Wr is never 1 outside PRE. Ram_Addr=0 and Ram_Din=0 in IDLE, GAP, DONE and ERR.

Test Plan:
- Nominal run: Start pulse; model Pre finishes after writing 5 words (addr 0..4); Fsm reads 0..4 then Finish with Fsm_Result=16'h002A -> one GAP cycle with Ram_Wr=0, Finish=1, Result=16'h002A, Fault_Code=00, no write outside PRE.
- FSM fault: Fsm_Fault and Fsm_Finish asserted together in EVAL -> ERR, Fault=1, Fault_Code=01, Result unchanged (0 after reset).
- Timeout: TIMEOUT=20, Pre_Finish never asserted -> ERR exactly 21 cycles after entering PRE, Fault_Code=10, Pre_En=0.
- Overflow: ADDR_W=4, Pre_Wr_Ptr reaches 15 with Pre_Finish=0 -> ERR, Fault_Code=11, Ram_Wr=0 the next cycle.
- Restart and ignore: Start during EVAL is ignored; Start in DONE -> Finish clears, one IDLE cycle with Pre_En=Fsm_En=0, then PRE, and a second run produces a new Result.
- Async reset mid-EVAL: drop Rst_n between clock edges -> all outputs 0 immediately; after release, the block stays IDLE until Start.
